sat_chan_sched: RTL and testbench
=================================

# sat_chan_sched

Per-channel configuration scheduler for the GPS synthesizer's bank of satellite channels. Accepts host writes of Doppler frequency word, gain, C/A tap select and enable into shadow registers, then commits all channels atomically on the next C/A code epoch strobe. Committed values drive the `freq`, `gain`, `ca_sel` and `enable` inputs of every satellite channel, so a reconfiguration never lands mid-code-period or splits across channels.

## Interface
- `NUM_CHAN`, default 8: number of satellite channels served, 1..16.
- `CHAN_W`, default 4: width of the channel index, at least `$clog2(NUM_CHAN)`.
- `clk`  in  1  sample clock shared with the satellite channels.
- `reset`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  host write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `wr_chan`  in  CHAN_W  target channel index.
- `wr_addr`  in  3  field select: 0 freq, 1 gain, 2 ca_sel, 3 enable, 4 freq rate (macro only).
- `wr_data`  in  32  field value, LSB-aligned.
- `wr_err`  out  1  one-cycle pulse, accepted write discarded (bad channel or field).
- `commit_req`  in  1  request to commit shadow registers to active registers.
- `epoch`  in  1  one-cycle strobe at each C/A code epoch (1 ms).
- `busy`  out  1  commit pending.
- `commit_done`  out  1  one-cycle pulse after a commit.
- `chan_enable`  out  NUM_CHAN  active enable per channel.
- `chan_freq`  out  32*NUM_CHAN  active frequency word; channel i occupies bits [32i+31:32i].
- `chan_gain`  out  16*NUM_CHAN  active gain, packed the same way.
- `chan_ca_sel`  out  6*NUM_CHAN  active C/A tap select, packed the same way.

## Operation
- States: IDLE and PENDING.
  - IDLE -> PENDING on `commit_req`.
  - PENDING -> IDLE on `epoch`.
  - `commit_req` while in PENDING is ignored.
- `wr_ready` is high in IDLE only. It is low in PENDING and while `reset` is high. Shadows cannot change during a pending commit.
- An accepted write updates one shadow field of `wr_chan`. Each field is truncated to its width: freq 32, gain 16, ca_sel 6, enable bit 0.
- An accepted write with `wr_chan >= NUM_CHAN` or an unsupported `wr_addr` changes nothing and pulses `wr_err` the next cycle.
- Commit happens on the clock edge where the state is PENDING and `epoch` is high:
  - all active registers for all channels are loaded from the shadows on that same edge;
  - `commit_done` is high for the following cycle.
- `epoch` in IDLE does not commit.
- `busy` = (state == PENDING).
- Reset clears all shadow and active registers to 0, sets the state to IDLE, and drives `wr_err`, `commit_done` and `busy` to 0. All outputs are therefore 0 after reset, and every channel is disabled.

## Timing
- Write-to-shadow latency: 1 cycle.
- Worst-case shadow-to-output latency: 1 cycle after `commit_req` registers, plus the wait for the next `epoch`, plus 1 cycle.
- `epoch` in the same cycle `commit_req` is accepted in IDLE: the state enters PENDING and the commit waits for the next epoch. There is no same-cycle commit.
- Write and `commit_req` in the same IDLE cycle: the write is accepted and is included in the commit.
- Reset asserted while PENDING: the commit is dropped, no `commit_done` pulse, and the state returns to IDLE.
- Active outputs are registered and change only on commit, on reset, or on a rate update (macro only).

## Configuration
- Macro: `SAT_CHAN_SCHED_DOPPLER_RATE_EN`.
- Defined:
  - adds a per-channel shadow and active 32-bit signed frequency rate at `wr_addr` 4, committed with the other fields;
  - on every `epoch` that does not commit, each enabled channel updates `freq <= freq + rate`, modulo 2^32 (wraps);
  - on a commit epoch, `freq` loads from the shadow with no rate added.
- Undefined:
  - `wr_addr` 4 is an unsupported field and pulses `wr_err`;
  - active `freq` changes only on commit.

## Test plan
- Reset, then idle 10 cycles -> all `chan_*` outputs 0, `wr_ready`=1, `busy`=0.
- Write ch2 freq=0x12345678, gain=0x4000, ca_sel=5, enable=1; `commit_req`; `epoch` 20 cycles later -> outputs unchanged until the epoch edge, then ch2 fields take the written values; `commit_done` one cycle high; other channels still 0.
- `commit_req` and `epoch` in the same cycle -> no commit; `busy`=1 and `wr_ready`=0 until the next `epoch`, then commit.
- Write `wr_chan`=NUM_CHAN, and separately `wr_addr`=7 -> `wr_err` pulses once per write; no state change.
- Reset mid-PENDING -> no `commit_done`, outputs 0, IDLE.
- Macro defined: ch0 freq=0xFFFFFFF0, rate=0x20, enable=1, commit; two further epochs -> freq 0x00000010, then 0x00000030 (wrap checked).

Source files
------------

// File: rtl/sat_chan_sched.sv
// rtl/sat_chan_sched.sv - per-channel shadow/active config scheduler, commits on C/A epoch (optional SAT_CHAN_SCHED_DOPPLER_RATE_EN)
module sat_chan_sched #(
    parameter int NUM_CHAN = 8,
    parameter int CHAN_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [CHAN_W-1:0]      wr_chan,
    input  logic [2:0]             wr_addr,
    input  logic [31:0]            wr_data,
    output logic                   wr_err,
    input  logic                   commit_req,
    input  logic                   epoch,
    output logic                   busy,
    output logic                   commit_done,
    output logic [NUM_CHAN-1:0]    chan_enable,
    output logic [32*NUM_CHAN-1:0] chan_freq,
    output logic [16*NUM_CHAN-1:0] chan_gain,
    output logic [6*NUM_CHAN-1:0]  chan_ca_sel
);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t state, state_nxt;

    logic [31:0] sh_freq  [NUM_CHAN];
    logic [15:0] sh_gain  [NUM_CHAN];
    logic [5:0]  sh_ca    [NUM_CHAN];
    logic        sh_en    [NUM_CHAN];
    logic [31:0] act_freq [NUM_CHAN];
    logic [15:0] act_gain [NUM_CHAN];
    logic [5:0]  act_ca   [NUM_CHAN];
    logic        act_en   [NUM_CHAN];
`ifdef SAT_CHAN_SCHED_DOPPLER_RATE_EN
    logic [31:0] sh_rate  [NUM_CHAN];
    logic [31:0] act_rate [NUM_CHAN];
`endif

    logic wr_acc, chan_ok, addr_ok, commit;

    assign wr_ready = (state == IDLE) && !reset;
    assign wr_acc   = wr_valid && wr_ready;
    assign chan_ok  = 32'(wr_chan) < 32'(NUM_CHAN);
`ifdef SAT_CHAN_SCHED_DOPPLER_RATE_EN
    assign addr_ok  = wr_addr <= 3'd4;
`else
    assign addr_ok  = wr_addr <= 3'd3;
`endif
    assign commit   = (state == PENDING) && epoch;
    assign busy     = (state == PENDING);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit_req) state_nxt = PENDING;
            PENDING: if (epoch)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err      <= 1'b0;
            commit_done <= 1'b0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                sh_freq[i]  <= '0;
                sh_gain[i]  <= '0;
                sh_ca[i]    <= '0;
                sh_en[i]    <= 1'b0;
                act_freq[i] <= '0;
                act_gain[i] <= '0;
                act_ca[i]   <= '0;
                act_en[i]   <= 1'b0;
`ifdef SAT_CHAN_SCHED_DOPPLER_RATE_EN
                sh_rate[i]  <= '0;
                act_rate[i] <= '0;
`endif
            end
        end else begin
            wr_err      <= wr_acc && !(chan_ok && addr_ok);
            commit_done <= commit;
            for (int i = 0; i < NUM_CHAN; i++) begin
                if (wr_acc && addr_ok && wr_chan == CHAN_W'(i)) begin
                    case (wr_addr)
                        3'd0: sh_freq[i] <= wr_data;
                        3'd1: sh_gain[i] <= wr_data[15:0];
                        3'd2: sh_ca[i]   <= wr_data[5:0];
                        3'd3: sh_en[i]   <= wr_data[0];
`ifdef SAT_CHAN_SCHED_DOPPLER_RATE_EN
                        3'd4: sh_rate[i] <= wr_data;
`endif
                        default: ;
                    endcase
                end
                if (commit) begin
                    act_freq[i] <= sh_freq[i];
                    act_gain[i] <= sh_gain[i];
                    act_ca[i]   <= sh_ca[i];
                    act_en[i]   <= sh_en[i];
`ifdef SAT_CHAN_SCHED_DOPPLER_RATE_EN
                    act_rate[i] <= sh_rate[i];
                end else if (epoch && act_en[i]) begin
                    // Doppler ramp: wraps modulo 2^32, skipped on the commit epoch
                    act_freq[i] <= act_freq[i] + act_rate[i];
`endif
                end
            end
        end
    end

    always_comb begin
        chan_enable = '0;
        chan_freq   = '0;
        chan_gain   = '0;
        chan_ca_sel = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            chan_enable[i]       = act_en[i];
            chan_freq[32*i +: 32] = act_freq[i];
            chan_gain[16*i +: 16] = act_gain[i];
            chan_ca_sel[6*i +: 6] = act_ca[i];
        end
    end

endmodule

// File: tb/tb_sat_chan_sched.sv
// tb/tb_sat_chan_sched.sv - directed self-checking bench for sat_chan_sched
module tb_sat_chan_sched;

    localparam int NUM_CHAN = 8;
    localparam int CHAN_W   = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [CHAN_W-1:0]      wr_chan;
    logic [2:0]             wr_addr;
    logic [31:0]            wr_data;
    logic                   wr_err;
    logic                   commit_req;
    logic                   epoch;
    logic                   busy;
    logic                   commit_done;
    logic [NUM_CHAN-1:0]    chan_enable;
    logic [32*NUM_CHAN-1:0] chan_freq;
    logic [16*NUM_CHAN-1:0] chan_gain;
    logic [6*NUM_CHAN-1:0]  chan_ca_sel;

    logic [NUM_CHAN-1:0]    exp_en;
    logic [32*NUM_CHAN-1:0] exp_freq;
    logic [16*NUM_CHAN-1:0] exp_gain;
    logic [6*NUM_CHAN-1:0]  exp_ca;

    int vectors = 0;
    int miscompares = 0;

    sat_chan_sched #(.NUM_CHAN(NUM_CHAN), .CHAN_W(CHAN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_chan     (wr_chan),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .commit_req  (commit_req),
        .epoch       (epoch),
        .busy        (busy),
        .commit_done (commit_done),
        .chan_enable (chan_enable),
        .chan_freq   (chan_freq),
        .chan_gain   (chan_gain),
        .chan_ca_sel (chan_ca_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " enable"}, 256'(chan_enable), 256'(exp_en));
        check({tag, " freq"},   256'(chan_freq),   256'(exp_freq));
        check({tag, " gain"},   256'(chan_gain),   256'(exp_gain));
        check({tag, " ca_sel"}, 256'(chan_ca_sel), 256'(exp_ca));
    endtask

    task automatic do_write(input logic [CHAN_W-1:0] ch, input logic [2:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_chan  = ch;
        wr_addr  = a;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_epoch();
        epoch = 1'b1;
        step();
        epoch = 1'b0;
    endtask

    task automatic pulse_commit_req();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_chan = '0; wr_addr = '0; wr_data = '0;
        commit_req = 1'b0; epoch = 1'b0;
        exp_en = '0; exp_freq = '0; exp_gain = '0; exp_ca = '0;

        // reset and idle
        repeat (3) step();
        check("wr_ready in reset", 256'(wr_ready), 256'(0));
        reset = 1'b0;
        repeat (10) step();
        check_outputs("after reset");
        check("wr_ready idle", 256'(wr_ready), 256'(1));
        check("busy idle", 256'(busy), 256'(0));
        check("wr_err idle", 256'(wr_err), 256'(0));
        check("commit_done idle", 256'(commit_done), 256'(0));

        // ch2 config, fields truncated to width
        do_write(4'd2, 3'd0, 32'h1234_5678);
        do_write(4'd2, 3'd1, 32'hABCD_4000);
        do_write(4'd2, 3'd2, 32'hFFFF_FFC5);
        do_write(4'd2, 3'd3, 32'h0000_0003);
        check("wr_err good write", 256'(wr_err), 256'(0));
        pulse_commit_req();
        check("busy pending", 256'(busy), 256'(1));
        check("wr_ready pending", 256'(wr_ready), 256'(0));
        repeat (19) step();
        check_outputs("before epoch");
        pulse_epoch();
        exp_freq[64 +: 32] = 32'h1234_5678;
        exp_gain[32 +: 16] = 16'h4000;
        exp_ca[12 +: 6]    = 6'd5;
        exp_en[2]          = 1'b1;
        check_outputs("ch2 commit");
        check("commit_done pulse", 256'(commit_done), 256'(1));
        check("busy after commit", 256'(busy), 256'(0));
        step();
        check("commit_done falls", 256'(commit_done), 256'(0));

        // write + commit_req + epoch in one IDLE cycle: no same-cycle commit
        wr_valid = 1'b1; wr_chan = 4'd5; wr_addr = 3'd0; wr_data = 32'hAAAA_0001;
        commit_req = 1'b1; epoch = 1'b1;
        step();
        wr_valid = 1'b0; commit_req = 1'b0; epoch = 1'b0;
        check("same-cycle busy", 256'(busy), 256'(1));
        check("same-cycle wr_ready", 256'(wr_ready), 256'(0));
        check("same-cycle no done", 256'(commit_done), 256'(0));
        check_outputs("same-cycle no commit");
        do_write(4'd5, 3'd1, 32'h0000_7777);
        check("pending write no err", 256'(wr_err), 256'(0));
        pulse_commit_req();
        repeat (3) step();
        check("still pending", 256'(busy), 256'(1));
        pulse_epoch();
        exp_freq[160 +: 32] = 32'hAAAA_0001;
        check_outputs("deferred commit");
        check("deferred done", 256'(commit_done), 256'(1));
        check("deferred idle", 256'(wr_ready), 256'(1));

        // discarded writes and idle epoch
        do_write(4'd8, 3'd0, 32'hDEAD_BEEF);
        check("err bad chan", 256'(wr_err), 256'(1));
        step();
        check("err one cycle", 256'(wr_err), 256'(0));
        do_write(4'd0, 3'd7, 32'hDEAD_BEEF);
        check("err bad addr", 256'(wr_err), 256'(1));
        do_write(4'd0, 3'd4, 32'h0000_0000);
`ifdef SAT_CHAN_SCHED_DOPPLER_RATE_EN
        check("addr4 rate ok", 256'(wr_err), 256'(0));
`else
        check("addr4 unsupported", 256'(wr_err), 256'(1));
`endif
        do_write(4'd1, 3'd0, 32'h0000_0055);
        pulse_epoch();
        check_outputs("idle epoch");
        check("idle epoch no done", 256'(commit_done), 256'(0));
        check("idle epoch busy", 256'(busy), 256'(0));

        // reset during pending drops the commit
        pulse_commit_req();
        step();
        reset = 1'b1; epoch = 1'b1;
        step();
        check("wr_ready reset high", 256'(wr_ready), 256'(0));
        reset = 1'b0; epoch = 1'b0;
        exp_en = '0; exp_freq = '0; exp_gain = '0; exp_ca = '0;
        check_outputs("reset mid-pending");
        check("reset no done", 256'(commit_done), 256'(0));
        check("reset busy", 256'(busy), 256'(0));
        pulse_epoch();
        check_outputs("epoch after reset");
        check("epoch after reset done", 256'(commit_done), 256'(0));

        // Doppler ramp with wrap (freq static without the macro)
        do_write(4'd0, 3'd0, 32'hFFFF_FFF0);
        do_write(4'd0, 3'd4, 32'h0000_0020);
        do_write(4'd0, 3'd3, 32'h0000_0001);
        pulse_commit_req();
        pulse_epoch();
        exp_en[0] = 1'b1;
        exp_freq[0 +: 32] = 32'hFFFF_FFF0;
        check_outputs("ch0 commit");
        pulse_epoch();
`ifdef SAT_CHAN_SCHED_DOPPLER_RATE_EN
        exp_freq[0 +: 32] = 32'h0000_0010;
`endif
        check("ramp epoch 1", 256'(chan_freq), 256'(exp_freq));
        check("ramp no done", 256'(commit_done), 256'(0));
        pulse_epoch();
`ifdef SAT_CHAN_SCHED_DOPPLER_RATE_EN
        exp_freq[0 +: 32] = 32'h0000_0030;
`endif
        check("ramp epoch 2", 256'(chan_freq), 256'(exp_freq));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
